// File: rtl/fetch_unit.sv
// Instruction fetch front end: holds the PC, issues word-aligned cache reads, and buffers
// returned instructions in a small FIFO for decode. Handles redirects, including during refill.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_cache_addr,
  output logic        o_cache_rd,
  input  logic [31:0] i_cache_inst,
  input  logic        i_cache_busy,
  input  logic        i_cache_hit,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       redir_q, redir_d;
  logic [31:0]       redir_tgt;
  logic [31:0]       fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]       fifo_inst_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              cap, pop, flush;
  logic              unused_redir_lsb;

  assign unused_redir_lsb = ^i_redirect_addr[1:0];
  assign redir_tgt        = {i_redirect_addr[31:2], 2'b00};

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_ADDR;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    case (state_q)
      StFetch: begin
        if (i_redirect) begin
          // A refill in flight keeps the address pinned; park the target until it finishes.
          if (i_cache_busy) begin
            redir_d = redir_tgt;
            state_d = StDrain;
          end else begin
            pc_d = redir_tgt;
          end
        end else if (cap) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StDrain: begin
        if (i_redirect) redir_d = redir_tgt;
        if (!i_cache_busy) begin
          pc_d    = i_redirect ? redir_tgt : redir_q;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Output logic
  always_comb begin
    o_cache_rd   = (state_q == StFetch) && (cnt_q < DepthCnt) && !i_reset;
    o_cache_addr = pc_q;
    cap          = o_cache_rd && i_cache_hit && !i_cache_busy && !i_redirect;
    pop          = o_valid && i_ready;
    flush        = i_redirect;
  end

  // FIFO control; a flush lets a same-cycle pop complete, then empties everything.
  always_ff @(posedge i_clock) begin
    if (i_reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (cap) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({cap, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (cap) begin
      fifo_pc_q[wr_ptr_q]   <= pc_q;
      fifo_inst_q[wr_ptr_q] <= i_cache_inst;
    end
  end

  assign o_valid = (cnt_q != '0);
  assign o_inst  = o_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign o_pc    = o_valid ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, and
// randomized traffic compared against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] ResetAddr = 32'h0000_0000;
  localparam int unsigned Depth     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cache_addr;
  logic        cache_rd;
  logic [31:0] cache_inst;
  logic        cache_busy;
  logic        cache_hit;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ready;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_ADDR(ResetAddr),
    .FIFO_DEPTH(Depth)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .o_cache_addr   (cache_addr),
    .o_cache_rd     (cache_rd),
    .i_cache_inst   (cache_inst),
    .i_cache_busy   (cache_busy),
    .i_cache_hit    (cache_hit),
    .i_redirect     (redirect),
    .i_redirect_addr(redirect_addr),
    .o_valid        (valid),
    .o_inst         (inst),
    .o_pc           (pc),
    .i_ready        (ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is a plain queue of {pc, inst} pairs.
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_drain;

  // Values sampled from the DUT at the last negedge
  logic        s_rd, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  typedef struct {
    logic        busy, hit, redir, ready;
    logic [31:0] inst, raddr;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic busy, input logic hit, input logic redir,
                      input logic rdy, input logic [31:0] ci, input logic [31:0] ra);
    bit          e_rd, e_valid, do_pop, do_cap;
    logic [31:0] e_pc, e_inst;
    rst = r; cache_busy = busy; cache_hit = hit; redirect = redir;
    ready = rdy; cache_inst = ci; redirect_addr = ra;
    e_rd    = !r && !m_drain && (mq.size() < Depth);
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_inst  = e_valid ? mq[0].inst : 32'h0;
    @(negedge clk);
    s_rd = cache_rd; s_addr = cache_addr; s_valid = valid; s_pc = pc; s_inst = inst;
    chk("model_rd",    {31'h0, s_rd},    {31'h0, e_rd});
    chk("model_addr",  s_addr,           m_pc);
    chk("model_valid", {31'h0, s_valid}, {31'h0, e_valid});
    chk("model_pc",    s_pc,             e_pc);
    chk("model_inst",  s_inst,           e_inst);
    @(posedge clk);
    if (r) begin
      mq.delete(); m_pc = ResetAddr; m_drain = 0; m_tgt = 32'h0;
    end else begin
      do_pop = e_valid && rdy;
      do_cap = e_rd && hit && !busy && !redir;
      if (do_pop) void'(mq.pop_front());
      if (redir) mq.delete();
      if (m_drain) begin
        if (redir) m_tgt = ra & 32'hFFFF_FFFC;
        if (!busy) begin m_pc = m_tgt; m_drain = 0; end
      end else if (redir) begin
        if (busy) begin m_tgt = ra & 32'hFFFF_FFFC; m_drain = 1; end
        else m_pc = ra & 32'hFFFF_FFFC;
      end else if (do_cap) begin
        mq.push_back('{pc: m_pc, inst: ci});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    // busy hit redir ready inst raddr | rd addr valid pc inst
    vecs[0]  = '{0,1,0,1, 32'h1111_0000, 0, 1, 32'h000, 0, 32'h000, 32'h0};
    vecs[1]  = '{0,1,0,1, 32'h1111_0004, 0, 1, 32'h004, 1, 32'h000, 32'h1111_0000};
    vecs[2]  = '{0,1,0,1, 32'h1111_0008, 0, 1, 32'h008, 1, 32'h004, 32'h1111_0004};
    vecs[3]  = '{0,1,0,0, 32'h1111_000C, 0, 1, 32'h00C, 1, 32'h008, 32'h1111_0008};
    vecs[4]  = '{0,1,0,0, 32'hBAD0_0010, 0, 0, 32'h010, 1, 32'h008, 32'h1111_0008};
    vecs[5]  = '{0,1,0,1, 32'hBAD0_0010, 0, 0, 32'h010, 1, 32'h008, 32'h1111_0008};
    vecs[6]  = '{0,1,0,1, 32'h1111_0010, 0, 1, 32'h010, 1, 32'h00C, 32'h1111_000C};
    vecs[7]  = '{0,0,0,1, 32'h0,         0, 1, 32'h014, 1, 32'h010, 32'h1111_0010};
    vecs[8]  = '{1,0,1,1, 32'h0, 32'h103,   1, 32'h014, 0, 32'h000, 32'h0};
    vecs[9]  = '{1,1,0,1, 32'hBAD0_0014, 0, 0, 32'h014, 0, 32'h000, 32'h0};
    vecs[10] = '{0,1,0,1, 32'hBAD0_0014, 0, 0, 32'h014, 0, 32'h000, 32'h0};
    vecs[11] = '{0,1,0,0, 32'h2222_0100, 0, 1, 32'h100, 0, 32'h000, 32'h0};
    vecs[12] = '{0,1,1,1, 32'hDEAD_0104, 32'h200, 1, 32'h104, 1, 32'h100, 32'h2222_0100};
    vecs[13] = '{0,1,0,1, 32'h3333_0200, 0, 1, 32'h200, 0, 32'h000, 32'h0};
    vecs[14] = '{0,0,0,1, 32'h0,         0, 1, 32'h204, 1, 32'h200, 32'h3333_0200};

    rst = 1; cache_busy = 0; cache_hit = 0; redirect = 0; ready = 0;
    cache_inst = 0; redirect_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_pc = ResetAddr; m_drain = 0; m_tgt = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_rd", {31'h0, s_rd}, 32'h0);
    chk("reset_addr", s_addr, ResetAddr);

    for (int i = 0; i < 15; i++) begin
      step(0, vecs[i].busy, vecs[i].hit, vecs[i].redir, vecs[i].ready, vecs[i].inst,
           vecs[i].raddr);
      chk($sformatf("vec%0d_rd", i),    {31'h0, s_rd},    {31'h0, vecs[i].e_rd});
      chk($sformatf("vec%0d_addr", i),  s_addr,           vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'h0, s_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d_pc", i),    s_pc,             vecs[i].e_pc);
      chk($sformatf("vec%0d_inst", i),  s_inst,           vecs[i].e_inst);
    end

    // Refill stall at 0x40
    step(0, 0, 0, 1, 1, 0, 32'h40);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 1, 32'hBAD0_0040, 0);
      chk("busy_addr_hold", s_addr, 32'h40);
    end
    step(0, 0, 1, 0, 1, 32'h4040_4040, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("busy_deliver_pc", s_pc, 32'h40);
    chk("busy_deliver_inst", s_inst, 32'h4040_4040);
    chk("busy_next_addr", s_addr, 32'h44);

    // Address wrap
    step(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFE);
    step(0, 0, 1, 0, 1, 32'h5555_0001, 0);
    chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 1, 32'h5555_0002, 0);
    chk("wrap_pc_top", s_pc, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 1, 32'h5555_0003, 0);
    chk("wrap_pc_zero", s_pc, 32'h0);

    // Reset while draining discards the parked redirect
    step(0, 1, 0, 1, 0, 0, 32'h500);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("drain_rd", {31'h0, s_rd}, 32'h0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("drain_reset_addr", s_addr, ResetAddr);
    chk("drain_reset_valid", {31'h0, s_valid}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(199) == 0), ($urandom_range(3) == 0), $urandom_range(1) == 1,
           ($urandom_range(15) == 0), ($urandom_range(9) < 6), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
